// File: rtl/join_sum_pkg.sv
// Shared constants and width helpers for the join-and-sum buffer.
package join_sum_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Headroom for the sum of n_ch operands without loss.
   function automatic int sum_width(input int d_width, input int n_ch);
      return d_width + $clog2(n_ch);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
   import join_sum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [count_width(DEPTH)-1:0]  count
);

   localparam int AW = ptr_width(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: contents are only observable through non-empty pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/join_sum_fifo.sv
// N-channel join-and-sum buffer: one FIFO per operand channel, heads are summed
// when every channel has data and the result is queued in an output FIFO.
module join_sum_fifo
   import join_sum_pkg::*;
#(
   parameter int D_WIDTH   = 6,
   parameter int N_CH      = 2,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int SAT_MODE  = MODE_WRAP
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_CH*D_WIDTH-1:0]      up_data,
   input  logic [N_CH-1:0]              push,
   output logic [N_CH-1:0]              in_full,
   output logic [D_WIDTH-1:0]           down_data,
   output logic                         down_sat,
   output logic                         down_valid,
   input  logic                         pop,
   output logic [$clog2(OUT_DEPTH):0]   out_count,
   output logic [N_CH-1:0]              ovf_err,
   output logic                         udf_err
);

   localparam int SUM_W = sum_width(D_WIDTH, N_CH);
   localparam logic [SUM_W-1:0] DATA_MAX = SUM_W'((1 << D_WIDTH) - 1);

   typedef struct packed {
      logic               sat;
      logic [D_WIDTH-1:0] data;
   } out_entry_t;

   logic [N_CH-1:0]                               in_push;
   logic [N_CH-1:0]                               in_empty;
   logic [N_CH-1:0][D_WIDTH-1:0]                  in_head;
   logic [N_CH-1:0][count_width(IN_DEPTH)-1:0]    in_count_unused;
   logic                                          join_en;
   logic                                          out_pop;
   logic                                          out_full;
   logic                                          out_empty;
   logic [SUM_W-1:0]                              sum;
   out_entry_t                                    join_entry;
   out_entry_t                                    out_head;

   // A full channel drops its push even if a join frees a slot this cycle.
   assign in_push = push & ~in_full;
   assign out_pop = pop & ~out_empty;
   assign join_en = (&(~in_empty)) & (~out_full | out_pop);

   for (genvar i = 0; i < N_CH; i++) begin : g_in
      sync_fifo #(
         .WIDTH (D_WIDTH),
         .DEPTH (IN_DEPTH)
      ) u_in_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (in_push[i]),
         .pop   (join_en),
         .wdata (up_data[i*D_WIDTH +: D_WIDTH]),
         .rdata (in_head[i]),
         .full  (in_full[i]),
         .empty (in_empty[i]),
         .count (in_count_unused[i])
      );
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum = sum + SUM_W'(in_head[i]);
      end
   end

   always_comb begin
      join_entry.sat  = 1'b0;
      join_entry.data = sum[D_WIDTH-1:0];
      if (SAT_MODE == MODE_SAT && sum > DATA_MAX) begin
         join_entry.sat  = 1'b1;
         join_entry.data = '1;
      end
   end

   sync_fifo #(
      .WIDTH (D_WIDTH + 1),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (join_en),
      .pop   (out_pop),
      .wdata (join_entry),
      .rdata (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   assign down_valid = ~out_empty;
   assign down_data  = out_empty ? '0 : out_head.data;
   assign down_sat   = out_empty ? 1'b0 : out_head.sat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_err <= '0;
         udf_err <= 1'b0;
      end else begin
         ovf_err <= ovf_err | (push & in_full);
         udf_err <= udf_err | (pop & out_empty);
      end
   end

endmodule

// File: tb/tb_join_sum_fifo.sv
// Self-checking bench: a 2-channel wrapping instance and a 3-channel saturating instance.
module tb_join_sum_fifo;
   import join_sum_pkg::*;

   localparam int DW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2*DW-1:0] up_data;
   logic [1:0]      push, in_full, ovf_err;
   logic [DW-1:0]   down_data;
   logic            down_sat, down_valid, pop, udf_err;
   logic [2:0]      out_count;

   logic [3*DW-1:0] up_data3;
   logic [2:0]      push3, in_full3, ovf_err3;
   logic [DW-1:0]   down_data3;
   logic            down_sat3, down_valid3, pop3, udf_err3;
   logic [2:0]      out_count3;

   join_sum_fifo #(.D_WIDTH(DW), .N_CH(2), .IN_DEPTH(4), .OUT_DEPTH(4), .SAT_MODE(MODE_WRAP)) dut (
      .clk(clk), .rst(rst), .up_data(up_data), .push(push), .in_full(in_full),
      .down_data(down_data), .down_sat(down_sat), .down_valid(down_valid), .pop(pop),
      .out_count(out_count), .ovf_err(ovf_err), .udf_err(udf_err));

   join_sum_fifo #(.D_WIDTH(DW), .N_CH(3), .IN_DEPTH(4), .OUT_DEPTH(4), .SAT_MODE(MODE_SAT)) dut3 (
      .clk(clk), .rst(rst), .up_data(up_data3), .push(push3), .in_full(in_full3),
      .down_data(down_data3), .down_sat(down_sat3), .down_valid(down_valid3), .pop(pop3),
      .out_count(out_count3), .ovf_err(ovf_err3), .udf_err(udf_err3));

   typedef struct {
      int a;
      int b;
      int exp_data;
   } vec_t;

   typedef struct packed {
      logic          sat;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[3];
   int   vec_count   = 0;
   int   miscompares = 0;

   function automatic exp_t mk(input logic sat, input int data);
      exp_t e;
      e.sat  = sat;
      e.data = DW'(data);
      return e;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int a, input int b, input logic pa, input logic pb);
      up_data = {DW'(b), DW'(a)};
      push    = {pb, pa};
   endtask

   // Compares the head against the scoreboard, then pops it through one edge.
   task automatic popAndCheck(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         vec_count++;
         miscompares++;
         $display("[TB] FAIL %s: scoreboard has no expected entry", name);
         return;
      end
      e = sb_q.pop_front();
      checkOutput({name, " valid"}, int'(down_valid), 1);
      checkOutput({name, " data"}, int'(down_data), int'(e.data));
      checkOutput({name, " sat"}, int'(down_sat), int'(e.sat));
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int peak;

      rst = 1'b0; push = '0; pop = 1'b0; up_data = '0;
      push3 = '0; pop3 = 1'b0; up_data3 = '0;
      tick(); tick();
      checkOutput("reset down_valid", int'(down_valid), 0);
      checkOutput("reset down_data", int'(down_data), 0);
      checkOutput("reset out_count", int'(out_count), 0);
      checkOutput("reset in_full", int'(in_full), 0);
      checkOutput("reset ovf_err", int'(ovf_err), 0);
      checkOutput("reset udf_err", int'(udf_err), 0);
      checkOutput("reset down_valid3", int'(down_valid3), 0);
      rst = 1'b1;
      tick();

      // Staggered operands: a at t0, b at t3, result visible at t5.
      applyStimulus(5, 0, 1'b1, 1'b0);
      tick();
      push = '0;
      checkOutput("lat t1 valid", int'(down_valid), 0);
      tick();
      checkOutput("lat t2 valid", int'(down_valid), 0);
      tick();
      applyStimulus(0, 9, 1'b0, 1'b1);
      sb_q.push_back(mk(1'b0, 5 + 9));
      checkOutput("lat t3 valid", int'(down_valid), 0);
      tick();
      push = '0;
      checkOutput("lat t4 valid", int'(down_valid), 0);
      tick();
      popAndCheck("lat t5");
      checkOutput("lat t6 valid", int'(down_valid), 0);
      checkOutput("lat t6 data", int'(down_data), 0);

      // Wrapping sums from a vector table, pushed back-to-back.
      tbl[0] = '{40, 30, 6};
      tbl[1] = '{63, 1, 0};
      tbl[2] = '{10, 0, 10};
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
         sb_q.push_back(mk(1'b0, tbl[i].exp_data));
         tick();
         if (int'(out_count) > peak) peak = int'(out_count);
      end
      push = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (int'(out_count) > peak) peak = int'(out_count);
      end
      checkOutput("wrap peak out_count", peak, 3);
      for (int i = 0; i < 3; i++) popAndCheck($sformatf("wrap pop%0d", i));

      // Saturating three-channel instance.
      up_data3 = {6'd10, 6'd30, 6'd30};
      push3 = 3'b111;
      tick();
      up_data3 = {6'd20, 6'd20, 6'd20};
      tick();
      push3 = '0;
      tick();
      checkOutput("sat0 valid", int'(down_valid3), 1);
      checkOutput("sat0 data", int'(down_data3), 63);
      checkOutput("sat0 sat", int'(down_sat3), 1);
      pop3 = 1'b1;
      tick();
      checkOutput("sat1 data", int'(down_data3), 60);
      checkOutput("sat1 sat", int'(down_sat3), 0);
      tick();
      pop3 = 1'b0;
      checkOutput("sat end valid", int'(down_valid3), 0);
      checkOutput("sat count", int'(out_count3), 0);

      // Overflow on channel a, then b pushes drain exactly four sums.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(k, 0, 1'b1, 1'b0);
         tick();
      end
      checkOutput("ovf in_full0", int'(in_full[0]), 1);
      checkOutput("ovf err before", int'(ovf_err[0]), 0);
      applyStimulus(5, 0, 1'b1, 1'b0);
      tick();
      push = '0;
      checkOutput("ovf err after", int'(ovf_err[0]), 1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(0, 10 * k, 1'b0, 1'b1);
         sb_q.push_back(mk(1'b0, 11 * k));
         tick();
      end
      push = '0;
      tick(); tick(); tick();
      checkOutput("ovf out_count", int'(out_count), 4);
      checkOutput("ovf in_full drained", int'(in_full), 0);
      for (int i = 0; i < 4; i++) popAndCheck($sformatf("ovf pop%0d", i));
      checkOutput("ovf no fifth", int'(down_valid), 0);
      applyStimulus(0, 50, 1'b0, 1'b1);
      tick();
      push = '0;
      tick(); tick();
      checkOutput("ovf a empty", int'(down_valid), 0);
      checkOutput("ovf sticky", int'(ovf_err[0]), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Output backpressure: six pairs, four fit, pop+join keeps count at four.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i + 1, 2 * i, 1'b1, 1'b1);
         sb_q.push_back(mk(1'b0, (3 * i + 1) % 64));
         tick();
      end
      push = '0;
      tick(); tick(); tick();
      checkOutput("bp out_count full", int'(out_count), 4);
      popAndCheck("bp pop0");
      checkOutput("bp count after pop+join", int'(out_count), 4);
      for (int i = 1; i < 6; i++) popAndCheck($sformatf("bp pop%0d", i));
      checkOutput("bp drained", int'(down_valid), 0);

      // Pop on empty output while a join lands: underflow plus valid result.
      checkOutput("udf before", int'(udf_err), 0);
      applyStimulus(3, 4, 1'b1, 1'b1);
      tick();
      push = '0;
      pop = 1'b1;
      tick();
      pop = 1'b0;
      checkOutput("udf set", int'(udf_err), 1);
      sb_q.push_back(mk(1'b0, 7));
      popAndCheck("udf join");

      // Mid-stream asynchronous reset with three results queued.
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(i, i, 1'b1, 1'b1);
         tick();
      end
      push = '0;
      tick(); tick();
      checkOutput("rst pre count", int'(out_count), 3);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst async valid", int'(down_valid), 0);
      checkOutput("rst async data", int'(down_data), 0);
      checkOutput("rst async count", int'(out_count), 0);
      checkOutput("rst async udf", int'(udf_err), 0);
      @(negedge clk);
      rst = 1'b1;
      tick(); tick();
      checkOutput("rst post valid", int'(down_valid), 0);
      checkOutput("rst post data", int'(down_data), 0);
      applyStimulus(9, 0, 1'b1, 1'b0);
      tick();
      push = '0;
      tick(); tick();
      checkOutput("rst no stale b", int'(down_valid), 0);
      checkOutput("scoreboard empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/join_sum_fifo.md
Name: join_sum_fifo

Overview:
- N-channel join-and-sum buffer: each upstream channel pushes operands into its own bounded FIFO.
- When every channel FIFO holds a head entry, the heads are summed and the result enters an output FIFO. The downstream side pops results from that FIFO.
- Synthesizable, parametrised successor of the two-channel adder queue. Adds backpressure, bounded depths, wrap/saturate mode and error flags.
- Sits between independent producer streams and a single consumer in the scenario datapaths.

Parameters:
- D_WIDTH, 6: width of each operand and of the result.
- N_CH, 2: number of input channels, 2..8.
- IN_DEPTH, 4: entries per input FIFO, power of two, >=2.
- OUT_DEPTH, 4: entries in the output FIFO, power of two, >=2.
- SAT_MODE, 0: 0 = result wraps modulo 2^D_WIDTH; 1 = result saturates to all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally).
- up_data  input  N_CH*D_WIDTH  channel i operand in bits [i*D_WIDTH +: D_WIDTH].
- push  input  N_CH  channel i write strobe.
- in_full  output  N_CH  channel i FIFO full, registered.
- down_data  output  D_WIDTH  head of output FIFO; 0 when empty.
- down_sat  output  1  head entry was clipped (SAT_MODE=1 only, else 0).
- down_valid  output  1  output FIFO non-empty.
- pop  input  1  consume head of output FIFO.
- out_count  output  $clog2(OUT_DEPTH)+1  output FIFO occupancy.
- ovf_err  output  N_CH  sticky: push while in_full.
- udf_err  output  1  sticky: pop while !down_valid.

Behaviour:
- Reset (rst=0): all FIFOs empty; outputs down_data=0, down_sat=0, down_valid=0, in_full=0, out_count=0, ovf_err=0, udf_err=0. Reset mid-operation discards all contents immediately.
- Push: channel i writes in cycle t if push[i] & !in_full[i]. The entry is head-visible from t+1.
- Full push: a push with in_full[i]=1 is dropped and sets ovf_err[i]. This holds even if a join frees a slot in the same cycle.
- Join condition: join_en = (all input FIFOs non-empty) & (out not full | pop). It uses registered occupancy only, so same-cycle pushes never join.
- Join effect: on join_en, pop one entry from every input FIFO and write the sum to the output FIFO in the same edge.
- Arithmetic: sum computed at D_WIDTH+$clog2(N_CH) bits, unsigned.
  - SAT_MODE=0: keep low D_WIDTH bits; down_sat stays 0.
  - SAT_MODE=1: if sum > 2^D_WIDTH-1, store all-ones with sat bit 1; otherwise store sum with sat bit 0.
- Latency: operands complete at cycle t appear on down_data/down_valid at t+2 (minimum).
- Pop: if pop & down_valid, the head is removed at the edge and the next entry (or 0) shows at t+1. Pop while empty is ignored and sets udf_err.
- Simultaneous pop and join with output full: both proceed and out_count is unchanged.
- Simultaneous pop and join with output empty: the join result is written, the pop is an underflow, and down_valid rises next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits plus a wrap bit; full/empty come from pointer compare. Wrap is transparent to data order.
- Ordering: results are strictly FIFO in join order. Channel FIFOs never reorder.
- Sticky flags clear only on reset.

Decomposition:
- Package join_sum_pkg holds:
  - localparam functions for count widths;
  - typedef out_entry_t {logic sat; logic [D_WIDTH-1:0] data} (parameterised through the module);
  - SAT_MODE encoding constants MODE_WRAP=0, MODE_SAT=1.
- One sub-module, sync_fifo (params WIDTH, DEPTH).
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Instantiated N_CH times for the inputs and once for the output at width D_WIDTH+1.
- The join/sum/saturate logic stays in the top module.

Test Plan:
- N_CH=2, SAT_MODE=0: push a=5 at t0, b=9 at t3. Expect down_valid=0 until t5, then down_data=14; pop at t5 gives down_valid=0 at t6.
- N_CH=2, wrap: push pairs (40,30), (63,1), (10,0) back-to-back. Expect down_data sequence 6, 0, 10 and out_count peaking at 3.
- N_CH=3, SAT_MODE=1: push (30,30,10) and (20,20,20). Expect 63 with down_sat=1, then 60 with down_sat=0.
- IN_DEPTH=4, no b pushes: push 5 entries on a. Expect in_full[0]=1 after the 4th, 5th dropped, ovf_err[0]=1. Later b pushes yield exactly 4 sums.
- OUT_DEPTH=4, no pops: push 6 pairs. Expect out_count=4, joins stall. Then pop and join in the same cycle keeps out_count=4, and the order is preserved.
- Pop on empty sets udf_err=1. Assert rst=0 mid-stream with 3 results queued: all outputs 0 asynchronously, and no stale data after release.
